// File: rtl/fetch_unit.sv
// Instruction-fetch front end: holds the PC, fetches one instruction at a time over a
// req/ack port and applies the decoder's PCSrc/Branch verdict when the datapath retires it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic [1:0]  PCSrc,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] rs_data,
    input  logic [31:0] ext_imm,
    output logic        addr_err,
    output logic [31:0] retired_count,
    output logic        fsm_state
);
    // Handshake: a fetch completes on a cycle where imem_req and imem_ack are both high;
    // imem_addr is held stable for as long as imem_req stays high.
    typedef enum logic {WAIT = 1'b0, HOLD = 1'b1} state_t;

    state_t      state;
    state_t      next_state;
    logic        req_q;
    logic        fetch_done;
    logic        retire_ok;
    logic        addr_err_q;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] next_pc;
    logic [31:0] count_q;

    assign fetch_done = (state == WAIT) && req_q && imem_ack;
    assign retire_ok  = (state == HOLD) && retire;
    assign pc_plus4   = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT:    if (fetch_done) next_state = HOLD;
            HOLD:    if (retire_ok)  next_state = WAIT;
            default: next_state = WAIT;
        endcase
    end

    always_comb begin
        imem_req      = req_q;
        imem_addr     = pc;
        instr_valid   = (state == HOLD);
        instr         = instr_q;
        OpCode        = instr_q[31:26];
        Funct         = instr_q[5:0];
        pc_out        = pc;
        addr_err      = addr_err_q;
        retired_count = count_q;
        fsm_state     = state;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            2'b01: next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
            2'b10: next_pc = {rs_data[31:2], 2'b00};
            2'b00: if (Branch && Zero) next_pc = pc_plus4 + {ext_imm[29:0], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    // The request register stays low for one cycle after reset so the first fetch
    // starts in the second cycle with reset low.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            instr_q    <= 32'd0;
            req_q      <= 1'b0;
            addr_err_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            addr_err_q <= 1'b0;
            if (state == WAIT) begin
                req_q <= !fetch_done;
            end else begin
                req_q <= retire_ok;
            end
            if (fetch_done) begin
                instr_q <= imem_rdata;
            end
            if (retire_ok) begin
                pc         <= next_pc;
                count_q    <= count_q + 32'd1;
                addr_err_q <= (PCSrc == 2'b10) && (rs_data[1:0] != 2'b00);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetch addresses go into a queue that a
// monitor drains on every accepted fetch; other outputs are checked inline.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        retire;
    logic [1:0]  PCSrc;
    logic        Branch;
    logic        Zero;
    logic [31:0] rs_data;
    logic [31:0] ext_imm;
    logic        addr_err;
    logic [31:0] retired_count;
    logic        fsm_state;

    int          n_pass = 0;
    int          n_total = 0;
    int          err_cycles = 0;
    int          wait_n;
    logic [31:0] exp_count = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .OpCode(OpCode),
        .Funct(Funct), .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .retire(retire), .PCSrc(PCSrc), .Branch(Branch), .Zero(Zero), .rs_data(rs_data),
        .ext_imm(ext_imm), .addr_err(addr_err), .retired_count(retired_count),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: every accepted fetch must match the next expected address.
    always @(negedge clk) begin
        if (!reset && imem_req && imem_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
            end else begin
                chk("fetch_addr", imem_addr, exp_q.pop_front());
            end
        end
        if (!reset && addr_err) err_cycles++;
    end

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int delay,
                         output int waited);
        exp_q.push_back(addr);
        waited = 0;
        while (!imem_req && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!imem_req) chk("req_timeout", 32'(imem_req), 32'd1);
        for (int i = 0; i < delay; i++) begin
            chk("addr_held", imem_addr, addr);
            @(posedge clk); #1;
        end
        imem_ack = 1'b1;
        imem_rdata = data;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("instr_valid_up", 32'(instr_valid), 32'd1);
        chk("instr_loaded", instr, data);
        chk("req_dropped", 32'(imem_req), 32'd0);
    endtask

    task automatic do_retire(input logic [1:0] src, input logic br, input logic z,
                             input logic [31:0] rs, input logic [31:0] imm);
        retire = 1'b1;
        PCSrc = src;
        Branch = br;
        Zero = z;
        rs_data = rs;
        ext_imm = imm;
        @(posedge clk); #1;
        retire = 1'b0;
        exp_count++;
        chk("retired_count", retired_count, exp_count);
        chk("valid_cleared", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; retire = 1'b0;
        PCSrc = 2'b00; Branch = 1'b0; Zero = 1'b0; rs_data = 32'd0; ext_imm = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_opcode", 32'(OpCode), 32'd0);
        chk("rst_count", retired_count, 32'd0);

        // Sequential stream, ack in first request cycle: 2 cycles per instruction.
        fetch(32'h0, 32'h0000_0020, 0, wait_n);
        chk("first_req_delay", 32'(wait_n), 32'd1);
        do_retire(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        fetch(32'h4, 32'h0000_0020, 0, wait_n);
        chk("b2b_req", 32'(wait_n), 32'd0);
        chk("pc_plus4", pc_plus4, 32'h8);
        do_retire(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        fetch(32'h8, 32'h0000_0020, 0, wait_n);
        do_retire(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("count_three", retired_count, 32'd3);

        // Delayed ack with a jal: target = {pc+4[31:28], instr[25:0], 00} = 0x00400010.
        reset = 1'b1; @(posedge clk); #1 reset = 1'b0; exp_count = 0;
        fetch(32'h0, 32'h0C10_0004, 3, wait_n);
        chk("jal_opcode", 32'(OpCode), 32'h03);
        chk("jal_funct", 32'(Funct), 32'h04);
        do_retire(2'b01, 1'b0, 1'b0, 32'd0, 32'd0);
        fetch(32'h0040_0010, 32'h0000_0008, 0, wait_n);
        do_retire(2'b10, 1'b0, 1'b0, 32'h0000_0020, 32'd0);
        chk("jr_aligned_no_err", 32'(addr_err), 32'd0);

        // beq at 0x20, imm -2: 0x24 - 8 = 0x1C.
        fetch(32'h20, 32'h1000_FFFE, 1, wait_n);
        do_retire(2'b00, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFE);
        // Misaligned jr: 0x46 -> 0x44 with a one-cycle addr_err.
        fetch(32'h1C, 32'h0060_0008, 0, wait_n);
        do_retire(2'b10, 1'b0, 1'b0, 32'h0000_0046, 32'd0);
        chk("addr_err_pulse", 32'(addr_err), 32'd1);
        chk("jr_target", imem_addr, 32'h44);
        @(posedge clk); #1;
        chk("addr_err_drop", 32'(addr_err), 32'd0);
        fetch(32'h44, 32'h0000_0008, 0, wait_n);
        do_retire(2'b10, 1'b0, 1'b0, 32'h0000_0040, 32'd0);
        fetch(32'h40, 32'h0000_0008, 0, wait_n);
        do_retire(2'b10, 1'b0, 1'b0, 32'h0000_0020, 32'd0);
        // beq not taken, then reserved PCSrc falls back to sequential.
        fetch(32'h20, 32'h1000_FFFE, 0, wait_n);
        do_retire(2'b00, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFE);
        fetch(32'h24, 32'h0000_0000, 0, wait_n);
        do_retire(2'b11, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0005);

        // Stray ack in HOLD is ignored.
        fetch(32'h28, 32'hAAAA_5555, 0, wait_n);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1 imem_ack = 1'b0;
        chk("stray_ack_instr", instr, 32'hAAAA_5555);
        chk("stray_ack_pc", pc_out, 32'h28);
        do_retire(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        // Retire in WAIT is ignored.
        retire = 1'b1; PCSrc = 2'b01;
        @(posedge clk); #1 retire = 1'b0;
        chk("wait_retire_count", retired_count, exp_count);
        chk("wait_retire_pc", pc_out, 32'h2C);

        // Reset during WAIT with ack in the same cycle.
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(posedge clk); #1 reset = 1'b0; imem_ack = 1'b0; exp_count = 0;
        chk("rstw_valid", 32'(instr_valid), 32'd0);
        chk("rstw_req", 32'(imem_req), 32'd0);
        chk("rstw_pc", pc_out, 32'd0);
        chk("rstw_count", retired_count, 32'd0);
        fetch(32'h0, 32'h0000_0020, 0, wait_n);
        chk("rstw_req_delay", 32'(wait_n), 32'd1);

        // Reset during HOLD with retire in the same cycle.
        reset = 1'b1; retire = 1'b1; PCSrc = 2'b00;
        @(posedge clk); #1 reset = 1'b0; retire = 1'b0;
        chk("rsth_valid", 32'(instr_valid), 32'd0);
        chk("rsth_count", retired_count, 32'd0);
        fetch(32'h0, 32'h0000_0020, 0, wait_n);
        do_retire(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);

        @(posedge clk); #1;
        chk("addr_err_cycles", 32'(err_cycles), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
